// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial line transmitter and its matching receiver.
//
// Contents:
//   state_e         2-bit frame state encoding (IDLE, START, DATA, STOP)
//   FRAME_OVERHEAD  number of non-data bits per frame (one start, one stop)
//   LINE_IDLE       level of the serial line when nothing is being sent
//   frame_cycles()  total clock cycles occupied by one frame
// -----------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int   FRAME_OVERHEAD = 2;
  localparam logic LINE_IDLE      = 1'b1;

  // Cycles from the accept edge until the line is ready for the next word.
  function automatic int frame_cycles(input int div, input int width);
    return (width + FRAME_OVERHEAD) * div;
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// -----------------------------------------------------------------------------
// serial_tx_if
// Handshake and line signals of the serial transmitter.
//
// Signals:
//   load   request to transmit din (producer -> transmitter)
//   din    parallel data word, WIDTH bits (producer -> transmitter)
//   ready  transmitter idle and able to accept load
//   Q      serial line, idle-high
//   Qbar   complement of Q
//
// Modports:
//   master  the word producer (testbench or upstream logic)
//   slave   the transmitter
// -----------------------------------------------------------------------------
interface serial_tx_if #(
  parameter int WIDTH = 8
);

  logic             load;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic             Q;
  logic             Qbar;

  modport master (
    output load,
    output din,
    input  ready,
    input  Q,
    input  Qbar
  );

  modport slave (
    input  load,
    input  din,
    output ready,
    output Q,
    output Qbar
  );

endinterface

// File: rtl/serial_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Modulo-DIV cycle counter that marks the last cycle of every serial bit.
//
// Ports:
//   C         system clock, rising edge
//   Rbar      asynchronous active-low reset
//   clear_i   restart the bit time; the cycle after clear is count 0
//   enable_i  count while a frame is on the line
//   tick_o    high for one cycle: the last cycle of the current bit time
// -----------------------------------------------------------------------------
module bit_timer #(
  parameter int DIV = 4
) (
  input  logic C,
  input  logic Rbar,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  // A one-bit counter is kept for DIV=1 so the vector stays legal; it then
  // sits at zero and every enabled cycle is a tick.
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge C or negedge Rbar) begin
    if (!Rbar) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A clear on the same cycle means a new frame is starting, not a bit ending.
  assign tick_o = enable_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
// Parallel-to-serial transmitter: one start bit (0), WIDTH data bits LSB
// first, one stop bit (1); every bit is held for DIV clock cycles.
//
// Parameters:
//   DIV    clock cycles per serial bit (1..255)
//   WIDTH  data bits per frame (1..16)
//
// Ports:
//   C     system clock, rising edge
//   Rbar  asynchronous active-low reset; aborts any frame in progress
//   bus   serial_tx_if slave: load/din in, ready/Q/Qbar out
//
// Timing: the start bit appears on the line from the accept edge, the frame
// lasts (WIDTH+2)*DIV cycles, and ready returns high for the cycle after the
// stop bit, where the next load may already be accepted.
// -----------------------------------------------------------------------------
module serial_tx
  import serial_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int WIDTH = 8
) (
  input  logic C,
  input  logic Rbar,
  serial_tx_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  // Holds the count of data bits already placed on the line, so it must be
  // able to represent WIDTH itself (16 needs five bits).
  localparam int             BCW      = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] BITS_ALL = BCW'(WIDTH);

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] shift_q,   shift_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             line_q,    line_d;
  logic             ready_q,   ready_d;

  logic accept;
  logic tick;

  assign accept = bus.load && ready_q;

  bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .C        (C),
    .Rbar     (Rbar),
    .clear_i  (accept),
    .enable_i (state_q != S_IDLE),
    .tick_o   (tick)
  );

  // Next line level is decided one edge ahead, so Q and ready come straight
  // from flops and never depend combinationally on load or din.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    line_d    = line_q;
    ready_d   = ready_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d   = bus.din;
          bit_cnt_d = '0;
          line_d    = 1'b0;
          ready_d   = 1'b0;
          state_d   = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          line_d    = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = BCW'(1);
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (tick) begin
          if (bit_cnt_q == BITS_ALL) begin
            line_d  = LINE_IDLE;
            state_d = S_STOP;
          end else begin
            line_d    = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        line_d  = LINE_IDLE;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge C or negedge Rbar) begin
    if (!Rbar) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      line_q    <= LINE_IDLE;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      line_q    <= line_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.Q     = line_q;
  assign bus.Qbar  = ~line_q;
  assign bus.ready = ready_q;

endmodule
